psg_spi_bridge: RTL and testbench
=================================

PSG_SPI_BRIDGE -- requirements
Module: psg_spi_bridge

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command bytes buffered; power of two, 2..16.
REQ-002 SHALL have parameter WRITE_GAP, default 32, minimum clk cycles between successive psg_we strobes; at least 1.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port spi_sck, input, 1, SPI clock (mode 0), asynchronous to clk.
REQ-006 SHALL have port spi_cs_n, input, 1, active-low frame select, asynchronous.
REQ-007 SHALL have port spi_mosi, input, 1, serial command data, MSB first.
REQ-008 SHALL have port spi_miso, output, 1, serial status byte, MSB first.
REQ-009 SHALL have port psg_data, output, 8, command byte presented to the PSG register-write port.
REQ-010 SHALL have port psg_we, output, 1, active-high single-cycle write strobe qualifying psg_data.
REQ-011 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.
REQ-012 SHALL have port overflow, output, 1, sticky flag: a received byte was dropped.

Function
REQ-013 SHALL pass spi_sck, spi_cs_n and spi_mosi each through a 2-flop synchronizer; edge detection uses synchronized sck and its previous value.
REQ-014 SHALL support SCK high and low phases of at least 3 clk periods each; faster SCK is out of scope.
REQ-015 SHALL, while synchronized cs_n is high, hold the bit counter at 0 and discard any partial byte.
REQ-016 SHALL, on each synchronized sck rising edge with cs_n low, shift synchronized mosi into the LSB of the shift register.
REQ-017 SHALL, on the 8th rising edge, form the byte, push it to the FIFO on the same clk edge, and wrap the bit counter to 0; multiple bytes per frame allowed.
REQ-018 SHALL, given clk edge N first sampling spi_sck high at the pin for the 8th bit, push the byte on edge N+3.
REQ-019 SHALL drop a byte pushed while the FIFO is full with no pop on that edge, and set overflow; FIFO contents unchanged.
REQ-020 SHALL accept a push to a full FIFO when a pop occurs on the same edge; level unchanged, overflow not set.
REQ-021 SHALL keep a gap counter; when the FIFO is non-empty and the gap counter is 0, pop the head, load psg_data with it, assert psg_we for exactly one cycle, and load the gap counter with WRITE_GAP-1.
REQ-022 SHALL decrement a non-zero gap counter by 1 each cycle, saturating at 0.
REQ-023 SHALL therefore assert psg_we no more often than once per WRITE_GAP cycles, bytes in FIFO order, none duplicated or lost except per REQ-019.
REQ-024 SHALL, when a byte is pushed into an empty FIFO with the gap counter 0, assert psg_we on the following edge (N+4).
REQ-025 SHALL hold psg_data at the last popped byte between strobes.
REQ-026 SHALL update fifo_level on the same edge as each push or pop; range 0..FIFO_DEPTH.
REQ-027 SHALL capture status byte {overflow, 0, 0, 0, level zero-extended to 4 bits} at bit counter 0; spi_miso presents its MSB, then shifts to the next bit on each synchronized sck falling edge with cs_n low.
REQ-028 SHALL drive spi_miso 0 while synchronized cs_n is high.

Reset
REQ-029 SHALL, on reset high at a clk edge, clear psg_data to 0x00, psg_we, overflow, spi_miso to 0, fifo_level to 0, gap counter to 0, bit counter, shift register and synchronizers to idle (sck 0, cs_n 1).
REQ-030 SHALL discard a partial byte and all FIFO contents on reset mid-frame; no psg_we until a new full byte after reset release.
REQ-031 SHALL clear overflow only by reset.

Verification
REQ-032 Single frame, byte 0x9F (ch0 attenuation off) -> one psg_we pulse, psg_data=0x9F, at edge N+4 per REQ-024.
REQ-033 One frame, bytes 0x80,0x3F,0x92 back-to-back, WRITE_GAP=32 -> three strobes 0x80,0x3F,0x92, exactly 32 cycles apart once queued.
REQ-034 Six bytes 0x01..0x06 in one burst, FIFO_DEPTH=4, WRITE_GAP=1000 -> 0x01 pops immediately, 0x02..0x05 queued, 0x06 dropped, overflow=1, fifo_level peaks at 4; strobes carry 0x01..0x05.
REQ-035 cs_n raised after 5 bits, then full frame 0xE4 -> only 0xE4 strobed; fifo_level never counts the partial byte.
REQ-036 Reset asserted after 3 of 8 bits and with 2 bytes queued -> all outputs 0, fifo_level 0, no strobe; next full byte 0xC5 strobes normally.
REQ-037 Read status with 2 bytes queued, overflow=1 -> miso returns 0x82 over 8 bits.

Source files
------------

// File: rtl/psg_spi_bridge.sv
// rtl/psg_spi_bridge.sv - SPI slave receiving PSG command bytes, buffered and paced onto a register-write strobe
module psg_spi_bridge #(
    parameter int FIFO_DEPTH = 4,
    parameter int WRITE_GAP  = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        spi_sck,
    input  logic                        spi_cs_n,
    input  logic                        spi_mosi,
    output logic                        spi_miso,
    output logic [7:0]                  psg_data,
    output logic                        psg_we,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int GW = $clog2(WRITE_GAP + 1);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(WRITE_GAP - 1);

    logic          sck_s1_q, sck_s1_d, sck_s2_q, sck_s2_d, sck_prev_q, sck_prev_d;
    logic          cs_s1_q, cs_s1_d, cs_s2_q, cs_s2_d;
    logic          mosi_s1_q, mosi_s1_d, mosi_s2_q, mosi_s2_d;
    logic          rise_q, rise_d, fall_q, fall_d;
    logic          mosi_bit_q, mosi_bit_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [6:0]    shift_q, shift_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [7:0]    fifo_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    psg_data_q, psg_data_d;
    logic          psg_we_q, psg_we_d;
    logic          overflow_q, overflow_d;

    logic          bit_act;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic [7:0]    rx_byte;
    logic [7:0]    status_byte;

    always_comb begin
        sck_s1_d   = spi_sck;
        sck_s2_d   = sck_s1_q;
        sck_prev_d = sck_s2_q;
        cs_s1_d    = spi_cs_n;
        cs_s2_d    = cs_s1_q;
        mosi_s1_d  = spi_mosi;
        mosi_s2_d  = mosi_s1_q;
        // Edges are registered once more so the data bit travels with its strobe.
        rise_d     = sck_s2_q & ~sck_prev_q;
        fall_d     = ~sck_s2_q & sck_prev_q;
        mosi_bit_d = rise_d ? mosi_s2_q : mosi_bit_q;
    end

    always_comb begin
        bit_act   = rise_q & ~cs_s2_q;
        rx_byte   = {shift_q, mosi_bit_q};
        push      = bit_act && (bit_cnt_q == 3'd7);
        full      = (level_q == FULL_LEVEL);
        pop       = (level_q != '0) && (gap_q == '0);
        push_ok   = push && (!full || pop);

        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        if (cs_s2_q) begin
            bit_cnt_d = 3'd0;
            shift_d   = 7'd0;
        end else if (bit_act) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = rx_byte[6:0];
        end

        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            fifo_d[wr_ptr_q] = rx_byte;
            wr_ptr_d         = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push_ok, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        overflow_d = overflow_q | (push & full & ~pop);

        if (pop) begin
            gap_d = GAP_RELOAD;
        end else if (gap_q != '0) begin
            gap_d = gap_q - GW'(1);
        end else begin
            gap_d = gap_q;
        end

        psg_data_d = pop ? fifo_q[rd_ptr_q] : psg_data_q;
        psg_we_d   = pop;

        // Status is reloaded for as long as no bit of the current byte has been clocked.
        status_byte = {overflow_q, 3'b000, 4'(level_q)};
        tx_d        = tx_q;
        if (bit_cnt_q == 3'd0) begin
            tx_d = status_byte;
        end else if (fall_q && !cs_s2_q) begin
            tx_d = {tx_q[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_s1_q   <= 1'b0;
            sck_s2_q   <= 1'b0;
            sck_prev_q <= 1'b0;
            cs_s1_q    <= 1'b1;
            cs_s2_q    <= 1'b1;
            mosi_s1_q  <= 1'b0;
            mosi_s2_q  <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            mosi_bit_q <= 1'b0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            tx_q       <= 8'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= 8'd0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            gap_q      <= '0;
            psg_data_q <= 8'd0;
            psg_we_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            sck_s1_q   <= sck_s1_d;
            sck_s2_q   <= sck_s2_d;
            sck_prev_q <= sck_prev_d;
            cs_s1_q    <= cs_s1_d;
            cs_s2_q    <= cs_s2_d;
            mosi_s1_q  <= mosi_s1_d;
            mosi_s2_q  <= mosi_s2_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            mosi_bit_q <= mosi_bit_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            gap_q      <= gap_d;
            psg_data_q <= psg_data_d;
            psg_we_q   <= psg_we_d;
            overflow_q <= overflow_d;
        end
    end

    assign spi_miso   = ~cs_s2_q & tx_q[7];
    assign psg_data   = psg_data_q;
    assign psg_we     = psg_we_q;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_psg_spi_bridge.sv
// tb/tb_psg_spi_bridge.sv - directed bench for psg_spi_bridge with a 32-cycle and a 1000-cycle pacing instance
module tb_psg_spi_bridge;

    logic       clk = 1'b0;
    logic       reset_a, reset_b;
    logic       sck, mosi, cs_a, cs_b;
    logic       miso_a, miso_b;
    logic [7:0] data_a, data_b;
    logic       we_a, we_b;
    logic [2:0] level_a, level_b;
    logic       ovf_a, ovf_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_n;
    int peak_a, peak_b;

    logic [7:0] qa_d[$];
    int         qa_c[$];
    logic [7:0] qb_d[$];
    int         qb_c[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    psg_spi_bridge #(.FIFO_DEPTH(4), .WRITE_GAP(32)) dut_a (
        .clk(clk), .reset(reset_a), .spi_sck(sck), .spi_cs_n(cs_a), .spi_mosi(mosi),
        .spi_miso(miso_a), .psg_data(data_a), .psg_we(we_a), .fifo_level(level_a), .overflow(ovf_a)
    );

    psg_spi_bridge #(.FIFO_DEPTH(4), .WRITE_GAP(1000)) dut_b (
        .clk(clk), .reset(reset_b), .spi_sck(sck), .spi_cs_n(cs_b), .spi_mosi(mosi),
        .spi_miso(miso_b), .psg_data(data_b), .psg_we(we_b), .fifo_level(level_b), .overflow(ovf_b)
    );

    always @(negedge clk) begin
        if (we_a === 1'b1) begin
            qa_d.push_back(data_a);
            qa_c.push_back(cyc);
        end
        if (we_b === 1'b1) begin
            qb_d.push_back(data_b);
            qb_c.push_back(cyc);
        end
        if (int'(level_a) > peak_a) peak_a = int'(level_a);
        if (int'(level_b) > peak_b) peak_b = int'(level_b);
    end

    function automatic logic [7:0] qa_at(input int k);
        return (k < qa_d.size()) ? qa_d[k] : 8'hxx;
    endfunction
    function automatic int qa_cyc(input int k);
        return (k < qa_c.size()) ? qa_c[k] : -1;
    endfunction
    function automatic logic [7:0] qb_at(input int k);
        return (k < qb_d.size()) ? qb_d[k] : 8'hxx;
    endfunction
    function automatic int qb_cyc(input int k);
        return (k < qb_c.size()) ? qb_c[k] : -1;
    endfunction

    task automatic set_cs(input bit sel_b, input logic v);
        if (sel_b) cs_b = v;
        else       cs_a = v;
    endtask

    task automatic frame_start(input bit sel_b);
        @(negedge clk);
        set_cs(sel_b, 1'b0);
        repeat (5) @(negedge clk);
    endtask

    task automatic frame_end(input bit sel_b);
        repeat (5) @(negedge clk);
        set_cs(sel_b, 1'b1);
        repeat (5) @(negedge clk);
    endtask

    task automatic spi_bits(input bit sel_b, input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            repeat (5) @(negedge clk);
            rx[i] = sel_b ? miso_b : miso_a;
            sck    = 1'b1;
            last_n = cyc + 1;
            repeat (5) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic wait_strobes(input bit sel_b, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if ((sel_b ? qb_d.size() : qa_d.size()) >= n) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset_a = 1'b1;
        reset_b = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({data_a, we_a, level_a, ovf_a, miso_a} !== 14'd0) begin
            bad++;
            $display("FAIL reset_a_outputs got=%h want=0", {data_a, we_a, level_a, ovf_a, miso_a});
        end
        total++;
        if ({data_b, we_b, level_b, ovf_b, miso_b} !== 14'd0) begin
            bad++;
            $display("FAIL reset_b_outputs got=%h want=0", {data_b, we_b, level_b, ovf_b, miso_b});
        end
        reset_a = 1'b0;
        reset_b = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if ({we_a, level_a, ovf_a, miso_a, we_b, level_b, ovf_b, miso_b} !== 12'd0) begin
            bad++;
            $display("FAIL idle_after_reset got=%h want=0", {we_a, level_a, ovf_a, miso_a, we_b, level_b, ovf_b, miso_b});
        end
    endtask

    task automatic test_single;
        logic [7:0] rx;
        int         n;
        qa_d.delete();
        qa_c.delete();
        frame_start(0);
        spi_bits(0, 8'h9F, 8, rx);
        n = last_n;
        frame_end(0);
        wait_strobes(0, 1, 200);
        total++;
        if (qa_d.size() != 1) begin
            bad++;
            $display("FAIL single_count got=%0d want=1", qa_d.size());
        end
        total++;
        if (qa_at(0) !== 8'h9F) begin
            bad++;
            $display("FAIL single_data got=%h want=9f", qa_at(0));
        end
        total++;
        if (qa_cyc(0) != n + 4) begin
            bad++;
            $display("FAIL single_latency got=%0d want=%0d", qa_cyc(0), n + 4);
        end
        repeat (10) @(negedge clk);
        total++;
        if ({data_a, we_a} !== {8'h9F, 1'b0}) begin
            bad++;
            $display("FAIL single_hold got=%h/%b want=9f/0", data_a, we_a);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] rx;
        logic [7:0] exp_d [3];
        int         exp_n [3];
        exp_d[0] = 8'h80;
        exp_d[1] = 8'h3F;
        exp_d[2] = 8'h92;
        qa_d.delete();
        qa_c.delete();
        frame_start(0);
        for (int k = 0; k < 3; k++) begin
            spi_bits(0, exp_d[k], 8, rx);
            exp_n[k] = last_n;
        end
        frame_end(0);
        wait_strobes(0, 3, 300);
        total++;
        if (qa_d.size() != 3) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=3", qa_d.size());
        end
        for (int k = 0; k < 3; k++) begin
            total++;
            if (qa_at(k) !== exp_d[k] || qa_cyc(k) != exp_n[k] + 4) begin
                bad++;
                $display("FAIL b2b_strobe%0d got=%h@%0d want=%h@%0d", k, qa_at(k), qa_cyc(k), exp_d[k], exp_n[k] + 4);
            end
        end
    endtask

    task automatic test_partial;
        logic [7:0] rx;
        int         n;
        qa_d.delete();
        qa_c.delete();
        peak_a = 0;
        frame_start(0);
        spi_bits(0, 8'hA8, 5, rx);
        frame_end(0);
        total++;
        if (level_a !== 3'd0 || peak_a != 0) begin
            bad++;
            $display("FAIL partial_level got=%0d peak=%0d want=0", level_a, peak_a);
        end
        frame_start(0);
        spi_bits(0, 8'hE4, 8, rx);
        n = last_n;
        frame_end(0);
        wait_strobes(0, 1, 200);
        repeat (50) @(negedge clk);
        total++;
        if (qa_d.size() != 1 || qa_at(0) !== 8'hE4 || qa_cyc(0) != n + 4) begin
            bad++;
            $display("FAIL partial_then_full got=%0d strobes first=%h@%0d want=1 e4@%0d", qa_d.size(), qa_at(0), qa_cyc(0), n + 4);
        end
        total++;
        if (peak_a != 1) begin
            bad++;
            $display("FAIL partial_peak got=%0d want=1", peak_a);
        end
    endtask

    task automatic test_overflow;
        logic [7:0] rx;
        int         n1;
        n1 = 0;
        qb_d.delete();
        qb_c.delete();
        peak_b = 0;
        frame_start(1);
        for (int k = 1; k <= 6; k++) begin
            spi_bits(1, 8'(k), 8, rx);
            if (k == 1) n1 = last_n;
        end
        frame_end(1);
        total++;
        if (level_b !== 3'd4 || ovf_b !== 1'b1) begin
            bad++;
            $display("FAIL ovf_state got=level %0d ovf %b want=level 4 ovf 1", level_b, ovf_b);
        end
        total++;
        if (peak_b != 4) begin
            bad++;
            $display("FAIL ovf_peak got=%0d want=4", peak_b);
        end
        total++;
        if (qb_d.size() != 1 || qb_at(0) !== 8'h01 || qb_cyc(0) != n1 + 4) begin
            bad++;
            $display("FAIL ovf_first got=%0d strobes %h@%0d want=1 01@%0d", qb_d.size(), qb_at(0), qb_cyc(0), n1 + 4);
        end
    endtask

    task automatic test_status;
        logic [7:0] rx;
        logic [7:0] exp_d [6];
        wait_strobes(1, 3, 2500);
        total++;
        if (qb_d.size() != 3) begin
            bad++;
            $display("FAIL gap_count got=%0d want=3", qb_d.size());
        end
        frame_start(1);
        spi_bits(1, 8'h00, 8, rx);
        frame_end(1);
        total++;
        if (rx !== 8'h82) begin
            bad++;
            $display("FAIL status_byte got=%h want=82", rx);
        end
        total++;
        if (ovf_b !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky got=%b want=1", ovf_b);
        end
        wait_strobes(1, 6, 3500);
        for (int k = 0; k < 5; k++) exp_d[k] = 8'(k + 1);
        exp_d[5] = 8'h00;
        total++;
        if (qb_d.size() != 6) begin
            bad++;
            $display("FAIL drain_count got=%0d want=6", qb_d.size());
        end
        for (int k = 0; k < 6; k++) begin
            total++;
            if (qb_at(k) !== exp_d[k]) begin
                bad++;
                $display("FAIL drain_data%0d got=%h want=%h", k, qb_at(k), exp_d[k]);
            end
        end
        for (int k = 1; k < 6; k++) begin
            total++;
            if (qb_cyc(k) - qb_cyc(k - 1) != 1000) begin
                bad++;
                $display("FAIL gap_spacing%0d got=%0d want=1000", k, qb_cyc(k) - qb_cyc(k - 1));
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] rx;
        int         n;
        @(negedge clk);
        reset_b = 1'b1;
        @(negedge clk);
        reset_b = 1'b0;
        qb_d.delete();
        qb_c.delete();
        frame_start(1);
        spi_bits(1, 8'h11, 8, rx);
        spi_bits(1, 8'h22, 8, rx);
        spi_bits(1, 8'h33, 8, rx);
        repeat (5) @(negedge clk);
        total++;
        if (level_b !== 3'd2 || qb_d.size() != 1) begin
            bad++;
            $display("FAIL mid_setup got=level %0d strobes %0d want=level 2 strobes 1", level_b, qb_d.size());
        end
        spi_bits(1, 8'hC5, 3, rx);
        reset_b = 1'b1;
        @(negedge clk);
        total++;
        if ({data_b, we_b, level_b, ovf_b, miso_b} !== 14'd0) begin
            bad++;
            $display("FAIL mid_reset_outputs got=%h want=0", {data_b, we_b, level_b, ovf_b, miso_b});
        end
        @(negedge clk);
        reset_b = 1'b0;
        qb_d.delete();
        qb_c.delete();
        repeat (3) @(negedge clk);
        cs_b = 1'b1;
        repeat (1200) @(negedge clk);
        total++;
        if (qb_d.size() != 0 || level_b !== 3'd0) begin
            bad++;
            $display("FAIL mid_no_strobe got=%0d strobes level %0d want=0", qb_d.size(), level_b);
        end
        frame_start(1);
        spi_bits(1, 8'hC5, 8, rx);
        n = last_n;
        frame_end(1);
        wait_strobes(1, 1, 200);
        total++;
        if (qb_d.size() != 1 || qb_at(0) !== 8'hC5 || qb_cyc(0) != n + 4) begin
            bad++;
            $display("FAIL mid_recover got=%0d strobes %h@%0d want=1 c5@%0d", qb_d.size(), qb_at(0), qb_cyc(0), n + 4);
        end
    endtask

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        sck     = 1'b0;
        mosi    = 1'b0;
        cs_a    = 1'b1;
        cs_b    = 1'b1;
        peak_a  = 0;
        peak_b  = 0;
        last_n  = 0;
        @(negedge clk);
        test_reset;
        test_single;
        test_back_to_back;
        test_partial;
        test_overflow;
        test_status;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
